cache_refill: RTL and testbench

Cache line refill engine: on a miss it fetches one 16-byte line from memory as four 32-bit beats and writes beat k into data bank k of the line at the miss index. It sits between the cache controller and the memory read channel, drives the bank write ports (`index`, `wr_en`, `wr_data`), and finally writes the tag. It forwards the missed (critical) word to the pipeline as soon as it arrives.

---
 rtl/cache_refill.sv | 120 ++++++++++++
 tb/tb_cache_refill.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill.sv
// Cache line refill engine: fetches a 16-byte line as four 32-bit beats into banks 0..3,
// forwards the critical word, then writes the tag.
module cache_refill #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_AW   = 8,
  parameter int TAG_W      = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_addr_i,
  output logic                  mem_ar_valid_o,
  input  logic                  mem_ar_ready_i,
  output logic [31:0]           mem_ar_addr_o,
  input  logic                  mem_r_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_r_data_i,
  input  logic                  mem_r_last_i,
  output logic                  mem_r_ready_o,
  output logic [INDEX_AW-1:0]   bank_index_o,
  output logic [15:0]           bank_wr_en_o,
  output logic [DATA_WIDTH-1:0] bank_wr_data_o,
  output logic                  tag_wr_en_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic                  crit_valid_o,
  output logic [DATA_WIDTH-1:0] crit_data_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {IDLE, AR, DATA, DONE} state_t;

  state_t     state;
  logic [1:0] cnt;
  logic [1:0] crit;
  logic [15:0] beat_mask;

  // Byte-offset bits never matter for a line fill.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr_i[1:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign beat_mask[4*gi +: 4] = {4{cnt == 2'(gi)}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 2'd0;
      crit           <= 2'd0;
      req_ready_o    <= 1'b1;
      mem_ar_valid_o <= 1'b0;
      mem_ar_addr_o  <= '0;
      mem_r_ready_o  <= 1'b0;
      bank_index_o   <= '0;
      bank_wr_en_o   <= '0;
      bank_wr_data_o <= '0;
      tag_wr_en_o    <= 1'b0;
      tag_o          <= '0;
      crit_valid_o   <= 1'b0;
      crit_data_o    <= '0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      bank_wr_en_o <= '0;
      crit_valid_o <= 1'b0;
      tag_wr_en_o  <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            tag_o          <= req_addr_i[31 -: TAG_W];
            bank_index_o   <= req_addr_i[4 +: INDEX_AW];
            crit           <= req_addr_i[3:2];
            mem_ar_addr_o  <= {req_addr_i[31:4], 4'b0000};
            cnt            <= 2'd0;
            err_o          <= 1'b0;
            req_ready_o    <= 1'b0;
            mem_ar_valid_o <= 1'b1;
            state          <= AR;
          end
        end
        AR: begin
          if (mem_ar_ready_i) begin
            mem_ar_valid_o <= 1'b0;
            mem_r_ready_o  <= 1'b1;
            state          <= DATA;
          end
        end
        DATA: begin
          if (mem_r_valid_i) begin
            bank_wr_data_o <= mem_r_data_i;
            bank_wr_en_o   <= beat_mask;
            if (cnt == crit) begin
              crit_valid_o <= 1'b1;
              crit_data_o  <= mem_r_data_i;
            end
            // The counter ends the refill; a misplaced last only flags an error.
            if (mem_r_last_i != (cnt == 2'd3)) begin
              err_o <= 1'b1;
            end
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              mem_r_ready_o <= 1'b0;
              tag_wr_en_o   <= 1'b1;
              done_o        <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill.sv
// Bench for cache_refill: transaction-level model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_cache_refill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        ar_valid;
  logic        ar_ready = 1'b0;
  logic [31:0] ar_addr;
  logic        r_valid = 1'b0;
  logic [31:0] r_data = '0;
  logic        r_last = 1'b0;
  logic        r_ready;
  logic [7:0]  bank_index;
  logic [15:0] bank_wr_en;
  logic [31:0] bank_wr_data;
  logic        tag_wr_en;
  logic [19:0] tag;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  cache_refill #(.DATA_WIDTH(32), .INDEX_AW(8), .TAG_W(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .mem_ar_valid_o(ar_valid), .mem_ar_ready_i(ar_ready), .mem_ar_addr_o(ar_addr),
    .mem_r_valid_i(r_valid), .mem_r_data_i(r_data), .mem_r_last_i(r_last),
    .mem_r_ready_o(r_ready),
    .bank_index_o(bank_index), .bank_wr_en_o(bank_wr_en), .bank_wr_data_o(bank_wr_data),
    .tag_wr_en_o(tag_wr_en), .tag_o(tag),
    .crit_valid_o(crit_valid), .crit_data_o(crit_data),
    .done_o(done), .err_o(err)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit started = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no event within cycle budget (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Model: a refill is "busy" from acceptance until the cycle after the fourth beat.
  bit          m_busy = 1'b0;
  bit          m_ar_wait = 1'b0;
  int          m_nb = 0;
  int          m_crit = 0;
  logic [31:0] e_ar_addr = '0;
  logic [7:0]  e_index = '0;
  logic [19:0] e_tag = '0;
  logic [15:0] e_wr_en = '0;
  logic [31:0] e_wr_data = '0;
  logic        e_crit_v = 1'b0;
  logic [31:0] e_crit_d = '0;
  logic        e_tag_wr = 1'b0;
  logic        e_done = 1'b0;
  logic        e_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_ar_wait = 1'b0; m_nb = 0; m_crit = 0;
      e_ar_addr = '0; e_index = '0; e_tag = '0; e_wr_en = '0; e_wr_data = '0;
      e_crit_v = 1'b0; e_crit_d = '0; e_tag_wr = 1'b0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      e_wr_en = '0; e_crit_v = 1'b0; e_tag_wr = 1'b0; e_done = 1'b0;
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1'b1; m_ar_wait = 1'b1; m_nb = 0; e_err = 1'b0;
          e_ar_addr = req_addr & 32'hFFFF_FFF0;
          e_tag     = 20'(req_addr / 32'd4096);
          e_index   = 8'((req_addr / 32'd16) % 32'd256);
          m_crit    = int'((req_addr / 32'd4) % 32'd4);
        end
      end else if (m_ar_wait) begin
        if (ar_ready) m_ar_wait = 1'b0;
      end else if (m_nb < 4) begin
        if (r_valid) begin
          e_wr_data = r_data;
          e_wr_en   = 16'(16'h000F << (4 * m_nb));
          if (m_nb == m_crit) begin
            e_crit_v = 1'b1;
            e_crit_d = r_data;
          end
          if (r_last != (m_nb == 3)) e_err = 1'b1;
          m_nb++;
          if (m_nb == 4) begin
            e_done = 1'b1;
            e_tag_wr = 1'b1;
          end
        end
      end else begin
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("ar_valid", 32'(ar_valid), 32'(m_busy && m_ar_wait));
      chk("ar_addr", ar_addr, e_ar_addr);
      chk("r_ready", 32'(r_ready), 32'(m_busy && !m_ar_wait && (m_nb < 4)));
      chk("bank_index", 32'(bank_index), 32'(e_index));
      chk("bank_wr_en", 32'(bank_wr_en), 32'(e_wr_en));
      chk("bank_wr_data", bank_wr_data, e_wr_data);
      chk("tag_wr_en", 32'(tag_wr_en), 32'(e_tag_wr));
      chk("tag", 32'(tag), 32'(e_tag));
      chk("crit_valid", 32'(crit_valid), 32'(e_crit_v));
      chk("crit_data", crit_data, e_crit_d);
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
    end
  end

  typedef struct {
    logic [15:0] en;
    logic [31:0] d;
    int          c;
  } wr_t;
  wr_t         wr_q[$];
  logic [31:0] crit_q[$];
  int          tag_seen = 0;

  always @(negedge clk) begin
    if (bank_wr_en != 16'h0000) wr_q.push_back('{en: bank_wr_en, d: bank_wr_data, c: cyc});
    if (crit_valid) crit_q.push_back(crit_data);
    if (tag_wr_en) tag_seen++;
  end

  // One refill: beat k carries base+k; vpat bit p gates valid on the p-th DATA slot.
  task automatic run_refill(input logic [31:0] addr, input logic [31:0] base, input int ar_stall,
                            input logic [7:0] vpat, input int vlen, input logic [3:0] last_on,
                            output int acc, output int dn, output logic [31:0] ar_a,
                            output logic [7:0] idx, output logic [19:0] tg);
    int beat;
    int p;
    logic v;
    acc = -1; dn = -1; ar_a = '0; idx = '0; tg = '0;
    req_valid = 1'b1;
    req_addr  = addr;
    for (int k = 0; k < 20 && !req_ready; k++) step();
    if (!req_ready) begin
      timeout("accept");
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    step();
    req_valid = 1'b0;
    ar_a = ar_addr;
    for (int k = 0; k < ar_stall; k++) begin
      ar_ready = 1'b0;
      step();
    end
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    beat = 0;
    p = 0;
    for (int k = 0; k < 40 && beat < 4; k++) begin
      v = (p < vlen) ? vpat[p] : 1'b1;
      p++;
      r_valid = v;
      r_data  = base + 32'(beat);
      r_last  = last_on[beat];
      step();
      if (v) beat++;
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    for (int k = 0; k < 20 && !done; k++) step();
    if (!done) begin
      timeout("done");
      return;
    end
    dn  = cyc;
    idx = bank_index;
    tg  = tag;
  endtask

  initial begin
    int acc, dn, acc2, dn2;
    logic [31:0] ar_a, ar_a2;
    logic [7:0] idx, idx2;
    logic [19:0] tg, tg2;
    logic [15:0] t1_en[4];
    int t3_cyc[4];
    t1_en = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000};
    t3_cyc = '{3, 6, 7, 9};

    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    started = 1'b1;
    step();
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_r_ready", 32'(r_ready), 32'd0);
    chk("reset_ar_valid", 32'(ar_valid), 32'd0);
    chk("reset_wr_en", 32'(bank_wr_en), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    // Zero-wait refill
    wr_q.delete(); crit_q.delete();
    run_refill(32'h0000_1A38, 32'hA0, 0, 8'h00, 0, 4'b1000, acc, dn, ar_a, idx, tg);
    chk("t1_ar_addr", ar_a, 32'h0000_1A30);
    chk("t1_index", 32'(idx), 32'hA3);
    chk("t1_tag", 32'(tg), 32'h00001);
    chk("t1_done_cycle", 32'(dn - acc + 1), 32'd7);
    chk("t1_err", 32'(err), 32'd0);
    step();
    chk("t1_wr_count", 32'(wr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      chk("t1_wr_en", 32'(wr_q[i].en), 32'(t1_en[i]));
      chk("t1_wr_data", wr_q[i].d, 32'hA0 + 32'(i));
      chk("t1_wr_cycle", 32'(wr_q[i].c - acc), 32'(3 + i));
    end
    chk("t1_crit_count", 32'(crit_q.size()), 32'd1);
    if (crit_q.size() > 0) chk("t1_crit_data", crit_q[0], 32'hA2);

    // AR backpressure
    wr_q.delete(); crit_q.delete();
    run_refill(32'h0000_3F0C, 32'hB0, 5, 8'h00, 0, 4'b1000, acc, dn, ar_a, idx, tg);
    chk("t2_done_cycle", 32'(dn - acc + 1), 32'd12);
    step();
    chk("t2_wr_count", 32'(wr_q.size()), 32'd4);
    if (wr_q.size() > 0) chk("t2_first_wr_cycle", 32'(wr_q[0].c - acc), 32'd8);
    if (crit_q.size() > 0) chk("t2_crit_data", crit_q[0], 32'hB3);

    // Beat gaps: valid pattern 1,0,0,1,1,0,1
    wr_q.delete(); crit_q.delete();
    run_refill(32'h0000_0100, 32'hC0, 0, 8'h59, 7, 4'b1000, acc, dn, ar_a, idx, tg);
    chk("t3_done_cycle", 32'(dn - acc + 1), 32'd10);
    step();
    chk("t3_wr_count", 32'(wr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      chk("t3_wr_cycle", 32'(wr_q[i].c - acc), 32'(t3_cyc[i]));
      chk("t3_wr_data", wr_q[i].d, 32'hC0 + 32'(i));
    end

    // Protocol error: last on beat 1
    wr_q.delete(); crit_q.delete();
    run_refill(32'h0000_5000, 32'hD0, 0, 8'h00, 0, 4'b0010, acc, dn, ar_a, idx, tg);
    chk("t4_done_cycle", 32'(dn - acc + 1), 32'd7);
    chk("t4_err_at_done", 32'(err), 32'd1);
    step();
    step();
    chk("t4_err_sticky", 32'(err), 32'd1);
    chk("t4_wr_count", 32'(wr_q.size()), 32'd4);

    // Reset mid-refill after beat 1
    tag_seen = 0;
    req_valid = 1'b1;
    req_addr = 32'h0000_2224;
    step();
    req_valid = 1'b0;
    chk("t5_err_cleared", 32'(err), 32'd0);
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    r_valid = 1'b1; r_data = 32'hF0; r_last = 1'b0;
    step();
    r_data = 32'hF1;
    step();
    r_valid = 1'b0;
    chk("t5_beat1_wr_en", 32'(bank_wr_en), 32'h00F0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_wr_en", 32'(bank_wr_en), 32'd0);
    chk("t5_rst_wr_data", bank_wr_data, 32'd0);
    chk("t5_rst_index", 32'(bank_index), 32'd0);
    chk("t5_rst_r_ready", 32'(r_ready), 32'd0);
    chk("t5_rst_req_ready", 32'(req_ready), 32'd1);
    chk("t5_rst_ar_addr", ar_addr, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t5_no_tag_write", 32'(tag_seen), 32'd0);
    run_refill(32'h0000_2224, 32'hE0, 0, 8'h00, 0, 4'b1000, acc, dn, ar_a, idx, tg);
    chk("t5_recover_done_cycle", 32'(dn - acc + 1), 32'd7);
    chk("t5_recover_tag", 32'(tg), 32'h00002);
    chk("t5_recover_tag_writes", 32'(tag_seen), 32'd1);

    // Back-to-back requests
    crit_q.delete();
    run_refill(32'h0000_0004, 32'h10, 0, 8'h00, 0, 4'b1000, acc, dn, ar_a, idx, tg);
    run_refill(32'hFFFF_FFF0, 32'h20, 0, 8'h00, 0, 4'b1000, acc2, dn2, ar_a2, idx2, tg2);
    chk("t6_accept_after_done", 32'(acc2 - dn), 32'd1);
    chk("t6_index1", 32'(idx), 32'h00);
    chk("t6_index2", 32'(idx2), 32'hFF);
    chk("t6_tag1", 32'(tg), 32'h00000);
    chk("t6_tag2", 32'(tg2), 32'hFFFFF);
    chk("t6_ar_addr2", ar_a2, 32'hFFFF_FFF0);
    chk("t6_done2_cycle", 32'(dn2 - acc2 + 1), 32'd7);
    step();
    chk("t6_crit_count", 32'(crit_q.size()), 32'd2);
    if (crit_q.size() > 1) begin
      chk("t6_crit1", crit_q[0], 32'h11);
      chk("t6_crit2", crit_q[1], 32'h20);
    end

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
